switch_allocator: RTL and testbench
===================================

SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter: P, default 7, meaning number of router ports; port 0 is the local port, and this matches the route engine's one-hot dest_port width.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  P  bit i is high when input i presents a flit.
REQ-005 req_port  input  P*P  slice [i*P +: P] is input i's one-hot destination port, taken from the route engine.
REQ-006 req_last  input  P  bit i marks the presented flit as the packet tail.
REQ-007 out_ready  input  P  bit j is high when output j can accept a flit this cycle.
REQ-008 grant  output  P  bit i means input i's flit transfers this cycle (pop).
REQ-009 out_valid  output  P  bit j means output j carries a valid flit this cycle.
REQ-010 out_sel  output  P*P  slice [j*P +: P] is the one-hot input index driving crossbar output j; all zeros when output j is idle.

Function
REQ-011 Each output j SHALL have an independent FSM with states IDLE and ACTIVE, plus registers owner[j] (one-hot, P bits) and ptr[j] (round-robin pointer, ceil(log2 P) bits).
REQ-012 Input i SHALL request output j in cycle t when req_valid[i] is high, req_port[i*P+j] is high, input i owns no output, and no IDLE-to-ACTIVE capture for input i occurs at this edge.
REQ-013 If req_port slice i is multi-hot, only its lowest set bit SHALL count; an all-zero slice SHALL raise no request.
REQ-014 In IDLE with at least one requester, output j SHALL pick the first requester at or after index ptr[j], wrapping from P-1 to 0.
REQ-015 On that edge, output j SHALL load owner[j] with the winner, go to ACTIVE, and set ptr[j] to (winner+1) mod P.
REQ-016 Arbitration latency SHALL be one cycle: no flit transfers in the capture cycle, and the first transfer can occur in the next cycle.
REQ-017 Several IDLE outputs contending for the same input in one cycle SHALL be resolved so that only the lowest-index output captures it; the other outputs stay IDLE.
REQ-018 In ACTIVE:
  - out_sel slice j SHALL equal owner[j].
  - out_valid[j] SHALL equal req_valid[owner] AND out_ready[j].
  - grant[owner] SHALL equal out_valid[j].
REQ-019 In ACTIVE, req_port of the owner SHALL be ignored; the packet stays on output j until its tail transfers.
REQ-020 A transfer with req_last high SHALL return output j to IDLE at that edge, clear owner[j], and leave ptr[j] unchanged.
REQ-021 A single-flit packet SHALL occupy exactly one capture cycle plus one transfer cycle.
REQ-022 If out_ready[j] is low, or the owner's req_valid is low, in ACTIVE:
  - the FSM SHALL hold its state;
  - grant and out_valid SHALL stay low;
  - there is no timeout.
REQ-023 grant SHALL never have a bit high for an input that is not an owner, and no input SHALL own two outputs at once.
REQ-024 grant, out_valid and out_sel SHALL be combinational from registered state and the current inputs, with no combinational path from req_port to grant.

Reset
REQ-025 While rst_n is low, every FSM SHALL be IDLE, with owner=0 and ptr=0; grant, out_valid and out_sel SHALL then read 0.
REQ-026 Reset asserted mid-packet SHALL abandon the packet immediately; after release, arbitration SHALL restart from ptr=0, and the flit source is responsible for flushing.

Verification
REQ-027 P=7, input 0 sends to output 2 (req_port=0000100) with req_last=1 and out_ready all high -> cycle 1 is capture with grant=0; cycle 2 has grant[0]=1, out_valid[2]=1, out_sel slice 2=0000001; then output 2 returns to IDLE.
REQ-028 Inputs 1, 3 and 5 continuously send single-flit packets to output 4 -> granted in order 1, 3, 5, 1, ..., with each grant gap equal to 2 cycles.
REQ-029 A 4-flit packet from input 2 to output 1 while input 6 also requests output 1 -> 4 consecutive grants to input 2; input 6 is captured in the cycle after input 2's tail transfers.
REQ-030 out_ready[3] held low for 5 cycles mid-packet -> grant and out_valid[3] stay 0 for those cycles, and the remaining flits follow in order once out_ready[3] rises.
REQ-031 rst_n pulsed low during ACTIVE -> all outputs read 0 asynchronously; after release, a fresh request is served starting from ptr=0.
REQ-032 Inputs 0 and 4 each send to a different output (E and N) in the same cycle -> both are captured in parallel and both transfer in the following cycle.

Source files
------------

// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin packet allocator for a P x P crossbar;
// each output holds its winning input until the packet tail transfers.
module switch_allocator #(
   parameter int P = 7
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [P-1:0]   req_valid,
   input  logic [P*P-1:0] req_port,
   input  logic [P-1:0]   req_last,
   input  logic [P-1:0]   out_ready,
   output logic [P-1:0]   grant,
   output logic [P-1:0]   out_valid,
   output logic [P*P-1:0] out_sel
);
   localparam int W = P > 1 ? $clog2(P) : 1;
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t       state [P];
   state_t       state_nx [P];
   logic [P-1:0] owner [P];
   logic [P-1:0] owner_nx [P];
   logic [W-1:0] ptr [P];
   logic [W-1:0] ptr_nx [P];
   logic [P-1:0] dest [P];
   logic [P-1:0] owned;
   // Lowest-set-bit decode makes every input target a single output, so two
   // idle outputs can never contend for the same input in one cycle.
   always_comb begin
      owned = '0;
      for (int i = 0; i < P; i++) begin
         dest[i] = req_port[i*P +: P] & (~req_port[i*P +: P] + P'(1));
         owned   = owned | owner[i];
      end
   end
   always_comb begin
      logic [P-1:0] reqs;
      logic [W-1:0] win;
      logic [W-1:0] idx;
      logic         found;
      grant     = '0;
      out_valid = '0;
      out_sel   = '0;
      reqs      = '0;
      win       = '0;
      idx       = '0;
      found     = 1'b0;
      for (int j = 0; j < P; j++) begin
         state_nx[j] = state[j];
         owner_nx[j] = owner[j];
         ptr_nx[j]   = ptr[j];
         reqs        = '0;
         win         = '0;
         found       = 1'b0;
         for (int i = 0; i < P; i++)
            reqs[i] = req_valid[i] & dest[i][j] & ~owned[i];
         for (int k = 0; k < P; k++) begin
            idx = W'((int'(ptr[j]) + k) % P);
            if (!found && reqs[idx]) begin
               found = 1'b1;
               win   = idx;
            end
         end
         out_sel[j*P +: P] = state[j] == ACTIVE ? owner[j] : '0;
         out_valid[j]      = state[j] == ACTIVE && |(owner[j] & req_valid) && out_ready[j];
         grant             = grant | (out_valid[j] ? owner[j] : '0);
         if (state[j] == IDLE && found) begin
            state_nx[j] = ACTIVE;
            owner_nx[j] = P'(1) << win;
            ptr_nx[j]   = W'((int'(win) + 1) % P);
         end else if (out_valid[j] && |(owner[j] & req_last)) begin
            state_nx[j] = IDLE;
            owner_nx[j] = '0;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < P; j++) begin
            state[j] <= IDLE;
            owner[j] <= '0;
            ptr[j]   <= '0;
         end
      end else begin
         for (int j = 0; j < P; j++) begin
            state[j] <= state_nx[j];
            owner[j] <= owner_nx[j];
            ptr[j]   <= ptr_nx[j];
         end
      end
   end
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed vectors with a transfer scoreboard for switch_allocator;
// stimulus queues expected (output, input) transfers, a negedge monitor pops them.
module tb_switch_allocator;
   localparam int P = 7;
   typedef struct {
      int o;
      int i;
   } exp_t;
   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [P-1:0]   req_valid = '0;
   logic [P*P-1:0] req_port = '0;
   logic [P-1:0]   req_last = '0;
   logic [P-1:0]   out_ready = '1;
   logic [P-1:0]   grant;
   logic [P-1:0]   out_valid;
   logic [P*P-1:0] out_sel;
   exp_t           q[$];
   int             n_checks = 0;
   int             n_errors = 0;
   int             seq [3] = '{1, 3, 5};
   logic [P-1:0]   g;
   switch_allocator #(.P(P)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_port(req_port),
      .req_last(req_last), .out_ready(out_ready), .grant(grant),
      .out_valid(out_valid), .out_sel(out_sel)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic push(input int o, input int i);
      exp_t e;
      e.o = o;
      e.i = i;
      q.push_back(e);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input int i, input logic [P-1:0] port, input logic v, input logic l);
      req_valid[i]       = v;
      req_port[i*P +: P] = port;
      req_last[i]        = l;
   endtask
   task automatic clear();
      req_valid = '0;
      req_port  = '0;
      req_last  = '0;
   endtask
   task automatic expect_cycle(input string name, input logic [P-1:0] eg, input logic [P-1:0] ov);
      @(negedge clk);
      chk({name, " grant"}, grant, eg);
      chk({name, " out_valid"}, out_valid, ov);
      tick();
   endtask
   // Monitor: every transferring output must match the oldest expected transfer.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n)
         for (int j = 0; j < P; j++)
            if (out_valid[j]) begin
               if (q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected transfer on out%0d: sel %0h, none expected", j, out_sel[j*P +: P]);
               end else begin
                  e = q.pop_front();
                  chk($sformatf("sb out%0d port", j), j, e.o);
                  chk($sformatf("sb out%0d sel", j), out_sel[j*P +: P], 64'(1) << e.i);
                  chk($sformatf("sb out%0d grant", j), grant[e.i], 1);
               end
            end
   end
   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("reset grant", grant, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_sel", out_sel, 0);
      tick();
      rst_n = 1'b1;
      // single-flit packet, input 0 -> output 2
      drive(0, 7'b0000100, 1'b1, 1'b1);
      push(2, 0);
      expect_cycle("t1 capture", '0, '0);
      expect_cycle("t1 xfer", 7'b0000001, 7'b0000100);
      clear();
      @(negedge clk);
      chk("t1 idle out_valid", out_valid, 0);
      chk("t1 idle out_sel", out_sel, 0);
      tick();
      // round robin among inputs 1,3,5 on output 4
      for (int i = 0; i < 3; i++) drive(seq[i], 7'b0010000, 1'b1, 1'b1);
      for (int k = 0; k < 6; k++) push(4, seq[k % 3]);
      for (int k = 0; k < 6; k++) begin
         expect_cycle("t2 capture", '0, '0);
         g = 7'(1) << seq[k % 3];
         expect_cycle($sformatf("t2 xfer%0d", k), g, 7'b0010000);
      end
      clear();
      // 4-flit packet from input 2 holds output 1 against input 6
      drive(6, 7'b0000010, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) push(1, 2);
      push(1, 6);
      for (int c = 0; c < 7; c++) begin
         drive(2, 7'b0000010, c <= 4, c == 4);
         g = (c >= 1 && c <= 4) ? 7'b0000100 : c == 6 ? 7'b1000000 : 7'b0;
         expect_cycle($sformatf("t3 c%0d", c), g, g != 0 ? 7'b0000010 : 7'b0);
      end
      clear();
      // out_ready[3] stalls a 4-flit packet for 5 cycles
      for (int k = 0; k < 4; k++) push(3, 3);
      for (int c = 0; c < 10; c++) begin
         out_ready[3] = !(c >= 3 && c <= 7);
         drive(3, 7'b0001000, 1'b1, c == 9);
         g = (c == 1 || c == 2 || c == 8 || c == 9) ? 7'b0001000 : 7'b0;
         expect_cycle($sformatf("t4 c%0d", c), g, g);
      end
      clear();
      out_ready = '1;
      // parallel captures; input 0 multi-hot resolves to output 5
      drive(0, 7'b1100000, 1'b1, 1'b1);
      drive(4, 7'b1000000, 1'b1, 1'b1);
      push(5, 0);
      push(6, 4);
      expect_cycle("t5 capture", '0, '0);
      expect_cycle("t5 xfer", 7'b0010001, 7'b1100000);
      clear();
      // reset mid-packet; output 4 pointer was left at 6
      drive(5, 7'b0010000, 1'b1, 1'b0);
      push(4, 5);
      push(4, 5);
      expect_cycle("t6 capture", '0, '0);
      expect_cycle("t6 flit0", 7'b0100000, 7'b0010000);
      expect_cycle("t6 flit1", 7'b0100000, 7'b0010000);
      rst_n = 1'b0;
      #1;
      chk("t6 async grant", grant, 0);
      chk("t6 async out_valid", out_valid, 0);
      chk("t6 async out_sel", out_sel, 0);
      tick();
      rst_n = 1'b1;
      drive(5, 7'b0010000, 1'b1, 1'b1);
      drive(6, 7'b0010000, 1'b1, 1'b1);
      push(4, 5);
      expect_cycle("t6 recapture", '0, '0);
      expect_cycle("t6 ptr0 winner", 7'b0100000, 7'b0010000);
      clear();
      repeat (3) tick();
      chk("scoreboard pending", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
